// File: rtl/pipeline_control_arbiter.sv
// -----------------------------------------------------------------------------
// lc3b_pipeline_pkg / pipeline_control_arbiter
//
// Purpose:
//   This block sits at the consumer end of the pipeline control-word request
//   interface. It collects control requests from every pipeline requester and
//   merges them into the one control word that drives the stage and barrier
//   stall, reset and force-load lines. A requester that asserts .exclusive can
//   take sole ownership of the control word. A watchdog limits how long one
//   requester can hold that ownership. The block also keeps saturating
//   stall and flush statistics.
//
// Ports:
//   clk              - system clock; all state updates on the rising edge
//   rst_n            - asynchronous, active-low reset
//   req_in           - NUM_REQ control requests; index 0 has the highest priority
//   control_out      - merged control word (combinational from req_in and state)
//   owner_valid      - an exclusive lock is currently held (registered)
//   owner            - index of the lock holder; 0 when no lock is held
//   lock_timeout_err - sticky flag, set when the watchdog breaks a lock
//   stall_cycles     - saturating count of cycles with any stall on control_out
//   flush_events     - saturating count of cycles with any barrier reset asserted
// -----------------------------------------------------------------------------
package lc3b_pipeline_pkg;

  // One request or merged control word. A word takes part in arbitration
  // only when .active=1. The .exclusive bit asks for sole ownership.
  typedef struct packed {
    logic active;
    logic exclusive;
    logic stage_if_stall;
    logic stage_id_stall;
    logic stage_ex_stall;
    logic stage_mem_stall;
    logic stage_wb_stall;
    logic barrier_if_id_stall;
    logic barrier_id_ex_stall;
    logic barrier_ex_mem_stall;
    logic barrier_mem_wb_stall;
    logic barrier_if_id_reset;
    logic barrier_id_ex_reset;
    logic barrier_ex_mem_reset;
    logic barrier_mem_wb_reset;
    logic force_sr1_load;
    logic force_sr2_load;
  } lc3b_pipeline_control_word;

endpackage

module pipeline_control_arbiter
  import lc3b_pipeline_pkg::*;
#(
  parameter int NUM_REQ      = 4,
  parameter int LOCK_TIMEOUT = 255,
  parameter int CNT_W        = 16,
  localparam int OWN_W       = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  lc3b_pipeline_control_word req_in [NUM_REQ],
  output lc3b_pipeline_control_word control_out,
  output logic                      owner_valid,
  output logic [OWN_W-1:0]          owner,
  output logic                      lock_timeout_err,
  output logic [CNT_W-1:0]          stall_cycles,
  output logic [CNT_W-1:0]          flush_events
);

  localparam int LCNT_W = (LOCK_TIMEOUT > 1) ? $clog2(LOCK_TIMEOUT) : 1;
  localparam logic [LCNT_W-1:0] LAST_HELD_CNT = LCNT_W'(LOCK_TIMEOUT - 1);

  typedef enum logic {
    IDLE   = 1'b0,
    LOCKED = 1'b1
  } arb_state_e;

  arb_state_e                state_q, state_d;
  logic [OWN_W-1:0]          owner_q, owner_d;
  logic [LCNT_W-1:0]         lock_cnt_q, lock_cnt_d;
  logic [NUM_REQ-1:0]        mask_q, mask_d;
  logic                      err_q, err_d;
  logic [CNT_W-1:0]          stall_q, stall_d;
  logic [CNT_W-1:0]          flush_q, flush_d;

  lc3b_pipeline_control_word merged;
  lc3b_pipeline_control_word ctrl;
  logic                      owner_holds;
  logic                      arbitrate;
  logic                      grant_found;
  logic [OWN_W-1:0]          grant_idx;
  logic                      any_stall;
  logic                      any_flush;

  // Next-state, selection and statistics logic. Every output of this block
  // first gets a hold or zero default. Exclusion of the old owner in a
  // release cycle needs no explicit term here. An owner that releases has
  // either dropped .active or dropped .exclusive, so it cannot be eligible
  // again in that cycle.
  always_comb begin
    state_d     = state_q;
    owner_d     = owner_q;
    lock_cnt_d  = lock_cnt_q;
    mask_d      = mask_q;
    err_d       = err_q;
    merged      = '0;
    ctrl        = '0;
    arbitrate   = 1'b1;
    grant_found = 1'b0;
    grant_idx   = '0;

    // Scan from the highest index down, so the lowest eligible index wins.
    // Inactive requesters also release any watchdog mask they carry.
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_in[i].active) begin
        merged = merged | req_in[i];
        if (req_in[i].exclusive && !mask_q[i]) begin
          grant_found = 1'b1;
          grant_idx   = OWN_W'(i);
        end
      end else begin
        mask_d[i] = 1'b0;
      end
    end
    merged.exclusive = 1'b0;

    owner_holds = (state_q == LOCKED) && req_in[owner_q].active &&
                  req_in[owner_q].exclusive;

    unique case (state_q)
      LOCKED: begin
        if (owner_holds) begin
          arbitrate = 1'b0;
          ctrl      = req_in[owner_q];
          if (lock_cnt_q == LAST_HELD_CNT) begin
            // Watchdog expiry: break the lock and demote the owner to a
            // non-exclusive requester until it goes inactive.
            state_d         = IDLE;
            owner_d         = '0;
            lock_cnt_d      = '0;
            mask_d[owner_q] = 1'b1;
            err_d           = 1'b1;
          end else begin
            lock_cnt_d = lock_cnt_q + 1'b1;
          end
        end
      end
      default: ;
    endcase

    // Idle evaluation. This path also runs in a release cycle, so a waiting
    // exclusive requester takes over without an idle gap.
    if (arbitrate) begin
      lock_cnt_d = '0;
      if (grant_found) begin
        ctrl    = req_in[grant_idx];
        state_d = LOCKED;
        owner_d = grant_idx;
      end else begin
        ctrl    = merged;
        state_d = IDLE;
        owner_d = '0;
      end
    end

    // A barrier that is being flushed must not also be held.
    if (ctrl.barrier_if_id_reset)  ctrl.barrier_if_id_stall  = 1'b0;
    if (ctrl.barrier_id_ex_reset)  ctrl.barrier_id_ex_stall  = 1'b0;
    if (ctrl.barrier_ex_mem_reset) ctrl.barrier_ex_mem_stall = 1'b0;
    if (ctrl.barrier_mem_wb_reset) ctrl.barrier_mem_wb_stall = 1'b0;

    any_stall = |{ctrl.stage_if_stall, ctrl.stage_id_stall, ctrl.stage_ex_stall,
                  ctrl.stage_mem_stall, ctrl.stage_wb_stall,
                  ctrl.barrier_if_id_stall, ctrl.barrier_id_ex_stall,
                  ctrl.barrier_ex_mem_stall, ctrl.barrier_mem_wb_stall};
    any_flush = |{ctrl.barrier_if_id_reset, ctrl.barrier_id_ex_reset,
                  ctrl.barrier_ex_mem_reset, ctrl.barrier_mem_wb_reset};

    stall_d = (any_stall && (stall_q != '1)) ? stall_q + 1'b1 : stall_q;
    flush_d = (any_flush && (flush_q != '1)) ? flush_q + 1'b1 : flush_q;
  end

  // All arbiter state: the FSM, the lock ownership and watchdog count, the
  // per-requester masks, the sticky error flag and the statistics. An
  // asynchronous reset clears everything at once. This also covers a reset
  // that arrives while a lock is held.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      owner_q    <= '0;
      lock_cnt_q <= '0;
      mask_q     <= '0;
      err_q      <= 1'b0;
      stall_q    <= '0;
      flush_q    <= '0;
    end else begin
      state_q    <= state_d;
      owner_q    <= owner_d;
      lock_cnt_q <= lock_cnt_d;
      mask_q     <= mask_d;
      err_q      <= err_d;
      stall_q    <= stall_d;
      flush_q    <= flush_d;
    end
  end

  // control_out is combinational. It is gated so that it reads zero while
  // reset is held, whatever the requesters drive.
  assign control_out      = rst_n ? ctrl : '0;
  assign owner_valid      = (state_q == LOCKED);
  assign owner            = owner_q;
  assign lock_timeout_err = err_q;
  assign stall_cycles     = stall_q;
  assign flush_events     = flush_q;

endmodule

// File: tb/tb_pipeline_control_arbiter.sv
// -----------------------------------------------------------------------------
// tb_pipeline_control_arbiter
//
// Purpose:
//   This is a self-checking bench for pipeline_control_arbiter. A reference
//   model follows the lock ownership as plain integers: it tracks whether a
//   lock is held, who holds it and how many cycles it has been held. It also
//   keeps a per-requester mask array and saturating counters. The model
//   predicts control_out and every registered output for each cycle. It runs
//   the directed scenarios first and then a long sticky-random sequence.
// -----------------------------------------------------------------------------
module tb_pipeline_control_arbiter;
  import lc3b_pipeline_pkg::*;

  localparam int NUM_REQ      = 4;
  localparam int LOCK_TIMEOUT = 4;
  localparam int CNT_W        = 4;
  localparam int CNT_MAX      = (1 << CNT_W) - 1;

  logic                      clk = 1'b0;
  logic                      rst_n;
  lc3b_pipeline_control_word req_in [NUM_REQ];
  lc3b_pipeline_control_word control_out;
  logic                      owner_valid;
  logic [1:0]                owner;
  logic                      lock_timeout_err;
  logic [CNT_W-1:0]          stall_cycles;
  logic [CNT_W-1:0]          flush_events;

  int testCount = 0;
  int failCount = 0;

  // Reference model state
  bit m_locked;
  int m_owner;
  int m_held;
  bit m_mask [NUM_REQ];
  bit m_err;
  int m_stall;
  int m_flush;

  lc3b_pipeline_control_word last_ctrl;
  lc3b_pipeline_control_word w [NUM_REQ];
  lc3b_pipeline_control_word tmp;

  pipeline_control_arbiter #(
    .NUM_REQ(NUM_REQ),
    .LOCK_TIMEOUT(LOCK_TIMEOUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_in(req_in),
    .control_out(control_out),
    .owner_valid(owner_valid),
    .owner(owner),
    .lock_timeout_err(lock_timeout_err),
    .stall_cycles(stall_cycles),
    .flush_events(flush_events)
  );

  always #5 clk = ~clk;

  // Counts one comparison and reports it if the observed value differs from
  // the expected one.
  task automatic checkOutput(input string tag, input logic [31:0] got,
                             input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic modelReset();
    m_locked = 1'b0;
    m_owner  = 0;
    m_held   = 0;
    m_err    = 1'b0;
    m_stall  = 0;
    m_flush  = 0;
    for (int i = 0; i < NUM_REQ; i++) m_mask[i] = 1'b0;
  endtask

  // Holds reset with all requesters idle and checks that every output reads
  // zero while reset is still low. It then releases reset on a falling edge.
  task automatic doReset();
    rst_n = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) req_in[i] = '0;
    #1;
    checkOutput("rst_control_out", 32'(control_out), 32'd0);
    checkOutput("rst_owner_valid", 32'(owner_valid), 32'd0);
    checkOutput("rst_owner", 32'(owner), 32'd0);
    checkOutput("rst_err", 32'(lock_timeout_err), 32'd0);
    checkOutput("rst_stall", 32'(stall_cycles), 32'd0);
    checkOutput("rst_flush", 32'(flush_events), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Drives one cycle of requests starting at a falling edge. It first checks
  // the registered outputs against the model state. It then applies the
  // arbitration rules to predict control_out and advances the model to the
  // state expected after the next rising edge.
  task automatic applyStimulus(input lc3b_pipeline_control_word s [NUM_REQ]);
    lc3b_pipeline_control_word e;
    int  win;
    int  old_owner;
    bit  timeout;
    for (int i = 0; i < NUM_REQ; i++) req_in[i] = s[i];
    #1;
    checkOutput("owner_valid", 32'(owner_valid), 32'(m_locked));
    checkOutput("owner", 32'(owner), 32'(m_owner));
    checkOutput("lock_timeout_err", 32'(lock_timeout_err), 32'(m_err));
    checkOutput("stall_cycles", 32'(stall_cycles), 32'(m_stall));
    checkOutput("flush_events", 32'(flush_events), 32'(m_flush));

    timeout   = 1'b0;
    old_owner = m_owner;
    if (m_locked && s[m_owner].active && s[m_owner].exclusive) begin
      e = s[m_owner];
      if (m_held == LOCK_TIMEOUT - 1) begin
        timeout  = 1'b1;
        m_locked = 1'b0;
        m_owner  = 0;
        m_held   = 0;
        m_err    = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      win = -1;
      for (int i = 0; i < NUM_REQ; i++)
        if (win < 0 && s[i].active && s[i].exclusive && !m_mask[i] &&
            !(m_locked && i == m_owner))
          win = i;
      if (win >= 0) begin
        e        = s[win];
        m_locked = 1'b1;
        m_owner  = win;
        m_held   = 0;
      end else begin
        e = '0;
        for (int i = 0; i < NUM_REQ; i++)
          if (s[i].active) e = e | s[i];
        e.exclusive = 1'b0;
        m_locked = 1'b0;
        m_owner  = 0;
        m_held   = 0;
      end
    end
    for (int i = 0; i < NUM_REQ; i++)
      if (!s[i].active) m_mask[i] = 1'b0;
    if (timeout) m_mask[old_owner] = 1'b1;

    if (e.barrier_if_id_reset)  e.barrier_if_id_stall  = 1'b0;
    if (e.barrier_id_ex_reset)  e.barrier_id_ex_stall  = 1'b0;
    if (e.barrier_ex_mem_reset) e.barrier_ex_mem_stall = 1'b0;
    if (e.barrier_mem_wb_reset) e.barrier_mem_wb_stall = 1'b0;

    checkOutput("control_out", 32'(control_out), 32'(e));
    last_ctrl = control_out;

    if ((e.stage_if_stall || e.stage_id_stall || e.stage_ex_stall ||
         e.stage_mem_stall || e.stage_wb_stall || e.barrier_if_id_stall ||
         e.barrier_id_ex_stall || e.barrier_ex_mem_stall ||
         e.barrier_mem_wb_stall) && m_stall < CNT_MAX)
      m_stall++;
    if ((e.barrier_if_id_reset || e.barrier_id_ex_reset ||
         e.barrier_ex_mem_reset || e.barrier_mem_wb_reset) && m_flush < CNT_MAX)
      m_flush++;

    @(negedge clk);
  endtask

  function automatic lc3b_pipeline_control_word randWord();
    lc3b_pipeline_control_word r;
    r           = lc3b_pipeline_control_word'($urandom);
    r.active    = ($urandom_range(0, 3) != 0);
    r.exclusive = ($urandom_range(0, 3) == 0);
    return r;
  endfunction

  task automatic clearWords();
    for (int i = 0; i < NUM_REQ; i++) w[i] = '0;
  endtask

  initial begin
    rst_n = 1'b1;
    for (int i = 0; i < NUM_REQ; i++) req_in[i] = '0;
    #2;
    doReset();

    // Merge of two non-exclusive requests, with flush dominance on IF/ID
    clearWords();
    w[0].active = 1'b1; w[0].stage_if_stall = 1'b1; w[0].barrier_if_id_reset = 1'b1;
    w[1].active = 1'b1; w[1].barrier_id_ex_stall = 1'b1; w[1].barrier_if_id_stall = 1'b1;
    applyStimulus(w);
    checkOutput("merge_if_id_stall", 32'(last_ctrl.barrier_if_id_stall), 32'd0);
    checkOutput("merge_if_id_reset", 32'(last_ctrl.barrier_if_id_reset), 32'd1);
    checkOutput("merge_id_ex_stall", 32'(last_ctrl.barrier_id_ex_stall), 32'd1);
    checkOutput("merge_exclusive", 32'(last_ctrl.exclusive), 32'd0);
    checkOutput("merge_stall_cnt", 32'(stall_cycles), 32'd1);
    checkOutput("merge_flush_cnt", 32'(flush_events), 32'd1);

    // Exclusive priority followed by handoff from requester 1 to requester 3
    doReset();
    clearWords();
    w[1].active = 1'b1; w[1].exclusive = 1'b1; w[1].stage_id_stall = 1'b1;
    w[3].active = 1'b1; w[3].exclusive = 1'b1; w[3].force_sr1_load = 1'b1;
    applyStimulus(w);
    checkOutput("prio_word", 32'(last_ctrl), 32'(w[1]));
    checkOutput("prio_owner_valid", 32'(owner_valid), 32'd1);
    checkOutput("prio_owner", 32'(owner), 32'd1);
    applyStimulus(w);
    checkOutput("prio_hold_word", 32'(last_ctrl), 32'(w[1]));
    w[1].active = 1'b0;
    applyStimulus(w);
    checkOutput("handoff_word", 32'(last_ctrl), 32'(w[3]));
    checkOutput("handoff_owner_valid", 32'(owner_valid), 32'd1);
    checkOutput("handoff_owner", 32'(owner), 32'd3);

    // Watchdog breaks requester 2's lock, masks it, and later re-grants it
    doReset();
    clearWords();
    w[0].active = 1'b1; w[0].stage_if_stall = 1'b1;
    w[2].active = 1'b1; w[2].exclusive = 1'b1; w[2].stage_ex_stall = 1'b1;
    for (int c = 0; c < 10; c++) applyStimulus(w);
    tmp = w[0] | w[2];
    tmp.exclusive = 1'b0;
    checkOutput("wd_owner_valid", 32'(owner_valid), 32'd0);
    checkOutput("wd_err", 32'(lock_timeout_err), 32'd1);
    checkOutput("wd_merged_word", 32'(last_ctrl), 32'(tmp));
    w[2].active = 1'b0;
    applyStimulus(w);
    w[2].active = 1'b1;
    applyStimulus(w);
    checkOutput("wd_regrant_owner", 32'(owner), 32'd2);
    checkOutput("wd_regrant_valid", 32'(owner_valid), 32'd1);
    checkOutput("wd_err_sticky", 32'(lock_timeout_err), 32'd1);

    // Stall counter saturation
    doReset();
    clearWords();
    w[0].active = 1'b1; w[0].stage_mem_stall = 1'b1;
    for (int c = 0; c < CNT_MAX + 5; c++) applyStimulus(w);
    checkOutput("sat_stall", 32'(stall_cycles), 32'(CNT_MAX));
    checkOutput("sat_flush", 32'(flush_events), 32'd0);

    // Asynchronous reset asserted between clock edges while a lock is held
    doReset();
    clearWords();
    w[1].active = 1'b1; w[1].exclusive = 1'b1; w[1].barrier_ex_mem_reset = 1'b1;
    applyStimulus(w);
    applyStimulus(w);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_control_out", 32'(control_out), 32'd0);
    checkOutput("arst_owner_valid", 32'(owner_valid), 32'd0);
    checkOutput("arst_owner", 32'(owner), 32'd0);
    checkOutput("arst_flush", 32'(flush_events), 32'd0);
    modelReset();
    @(negedge clk);
    rst_n = 1'b1;
    w[1].exclusive = 1'b0;
    applyStimulus(w);
    checkOutput("arst_passthru", 32'(last_ctrl), 32'(w[1]));

    // Sticky random traffic: each requester keeps its word for a few cycles,
    // so locks are held, handed over and broken by the watchdog.
    doReset();
    for (int i = 0; i < NUM_REQ; i++) w[i] = randWord();
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < NUM_REQ; i++)
        if ($urandom_range(0, 3) == 0) w[i] = randWord();
      applyStimulus(w);
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
